// File: rtl/adder_tree_in_packer_if.sv
// Stream-in / frame-out bus between a serial sample source, the packer and the CSA adder tree.
// Slot 0 of o_data sits in the most significant bits and holds the first-received sample.
interface adder_tree_in_packer_if #(
  parameter int I_DATA_W = 3,
  parameter int I_DATA_N = 8
);
  logic [I_DATA_W-1:0]                 i_data;
  logic                                i_valid;
  logic                                o_ready;
  logic                                i_flush;
  logic [0:I_DATA_N-1][I_DATA_W-1:0]   o_data;
  logic                                o_valid;
  logic                                i_ready;
  logic                                o_partial;

  modport slave (
    input  i_data, i_valid, i_flush, i_ready,
    output o_ready, o_data, o_valid, o_partial
  );

  modport master (
    output i_data, i_valid, i_flush, i_ready,
    input  o_ready, o_data, o_valid, o_partial
  );
endinterface

// File: rtl/adder_tree_in_packer.sv
// Packs a serial sample stream into I_DATA_N-word frames for the CSA adder tree.
// Double-buffered: a fill buffer backs a registered output frame; flush zero-pads partial frames.
module adder_tree_in_packer_slot #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] nxt_o
);
  // nxt_o is the slot's content with this cycle's write folded in.
  assign nxt_o = we_i ? d_i : q_o;

  always_ff @(posedge clk) begin
    if (rst || clr_i) q_o <= '0;
    else if (we_i)    q_o <= d_i;
  end
endmodule

module adder_tree_in_packer #(
  parameter int I_DATA_W = 3,
  parameter int I_DATA_N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_tree_in_packer_if.slave bus_s
);
  localparam int IDX_W = $clog2(I_DATA_N);

  typedef enum logic {FILL, FULL} state_e;

  state_e                              state_q;
  logic [IDX_W-1:0]                    wr_idx_q;
  logic [0:I_DATA_N-1][I_DATA_W-1:0]   buf_q, frame_d, o_data_q;
  logic                                o_valid_q, o_partial_q, part_hold_q;
  logic                                accept, slot_free, last, flush_close, complete, partial, buf_clr;

  assign bus_s.o_ready   = (state_q == FILL) && !rst;
  assign bus_s.o_data    = o_data_q;
  assign bus_s.o_valid   = o_valid_q;
  assign bus_s.o_partial = o_partial_q;

  assign accept      = bus_s.i_valid && bus_s.o_ready;
  assign slot_free   = !o_valid_q || bus_s.i_ready;
  assign last        = accept && (wr_idx_q == IDX_W'(I_DATA_N - 1));
  assign flush_close = (state_q == FILL) && bus_s.i_flush && ((wr_idx_q != '0) || accept);
  assign complete    = (state_q == FILL) && (last || flush_close);
  assign partial     = flush_close && !last;
  // Buffer empties whenever its frame moves into the output register.
  assign buf_clr     = slot_free && (complete || (state_q == FULL));

  for (genvar g = 0; g < I_DATA_N; g++) begin : g_slot
    adder_tree_in_packer_slot #(.W(I_DATA_W)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .clr_i (buf_clr),
      .we_i  (accept && (wr_idx_q == IDX_W'(g))),
      .d_i   (bus_s.i_data),
      .q_o   (buf_q[g]),
      .nxt_o (frame_d[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      wr_idx_q    <= '0;
      o_data_q    <= '0;
      o_valid_q   <= 1'b0;
      o_partial_q <= 1'b0;
      part_hold_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (complete) begin
            wr_idx_q <= '0;
            if (slot_free) begin
              o_data_q    <= frame_d;
              o_valid_q   <= 1'b1;
              o_partial_q <= partial;
            end else begin
              part_hold_q <= partial;
              state_q     <= FULL;
            end
          end else begin
            if (accept)                        wr_idx_q  <= wr_idx_q + 1'b1;
            if (o_valid_q && bus_s.i_ready)    o_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (slot_free) begin
            o_data_q    <= buf_q;
            o_valid_q   <= 1'b1;
            o_partial_q <= part_hold_q;
            wr_idx_q    <= '0;
            state_q     <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_tree_in_packer.sv
// Directed bench for adder_tree_in_packer: a queue-based frame model checked every cycle,
// plus hand-computed frame literals for each scenario.
module tb_adder_tree_in_packer;
  localparam int W = 3;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;

  adder_tree_in_packer_if #(.I_DATA_W(W), .I_DATA_N(N)) bus ();

  adder_tree_in_packer #(.I_DATA_W(W), .I_DATA_N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_s (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: words collected so far, one output frame, at most one frame waiting behind it.
  logic [W-1:0]   cur[$];
  logic           m_ov = 1'b0, m_part = 1'b0, m_held = 1'b0, m_hpart = 1'b0;
  logic [N*W-1:0] m_od = '0, m_hd = '0, m_f;
  logic           m_consume, m_p;
  int             cyc = 0;

  function automatic logic [N*W-1:0] pack_frame();
    logic [N*W-1:0] f = '0;
    for (int i = 0; i < cur.size(); i++) f[(N-1-i)*W +: W] = cur[i];
    return f;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      cur.delete();
      m_ov = 1'b0; m_part = 1'b0; m_od = '0; m_held = 1'b0;
    end else begin
      m_consume = m_ov && bus.i_ready;
      if (m_held) begin
        if (!m_ov || m_consume) begin
          m_od = m_hd; m_part = m_hpart; m_ov = 1'b1; m_held = 1'b0;
        end
      end else begin
        if (bus.i_valid) cur.push_back(bus.i_data);
        if (cur.size() == N || (bus.i_flush && cur.size() > 0)) begin
          m_f = pack_frame();
          m_p = (cur.size() < N);
          cur.delete();
          if (!m_ov || m_consume) begin
            m_od = m_f; m_part = m_p; m_ov = 1'b1;
          end else begin
            m_hd = m_f; m_hpart = m_p; m_held = 1'b1;
          end
        end else if (m_consume) begin
          m_ov = 1'b0;
        end
      end
    end
  end

  int          hs = 0;
  int          hs_t[$];
  logic [31:0] last_data = '0;
  logic        last_part = 1'b0;
  logic        rdy_drop = 1'b0;

  always @(negedge clk) begin
    check("o_ready", 32'(bus.o_ready), 32'(!rst && !m_held));
    check("o_valid", 32'(bus.o_valid), 32'(m_ov));
    if (m_ov) begin
      check("o_data", 32'(bus.o_data), 32'(m_od));
      check("o_partial", 32'(bus.o_partial), 32'(m_part));
    end
    if (bus.o_valid) begin
      last_data = 32'(bus.o_data);
      last_part = bus.o_partial;
    end
    if (bus.o_valid && bus.i_ready) begin
      hs++;
      hs_t.push_back(cyc);
    end
    if (!bus.o_ready && !rst) rdy_drop = 1'b1;
  end

  task automatic step(input bit v, input logic [W-1:0] d, input bit f);
    bus.i_valid = v; bus.i_data = d; bus.i_flush = f; bus.i_ready = rdy;
    @(posedge clk); #1;
  endtask

  logic [W-1:0] w1 [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7};

  initial begin
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_flush = 1'b0; bus.i_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", 32'(bus.o_valid), 32'd0);
    check("rst_o_data", 32'(bus.o_data), 32'd0);
    check("rst_o_partial", 32'(bus.o_partial), 32'd0);
    check("rst_o_ready", 32'(bus.o_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_o_ready", 32'(bus.o_ready), 32'd1);

    // 1: one full frame, downstream always ready
    rdy = 1'b1; hs = 0;
    foreach (w1[i]) step(1'b1, w1[i], 1'b0);
    check("t1_valid_after_8th", 32'(bus.o_valid), 32'd1);
    step(1'b0, '0, 1'b0);
    check("t1_frames", 32'(hs), 32'd1);
    check("t1_data", last_data, 32'h29CBBF);
    check("t1_partial", 32'(last_part), 32'd0);

    // 2: back-pressure fills both buffers
    rdy = 1'b0; hs = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 3'(7 - i), 1'b0);
    check("t2_ready_full", 32'(bus.o_ready), 32'd0);
    check("t2_held_data", 32'(bus.o_data), 32'h053977);
    rdy = 1'b1;
    step(1'b0, '0, 1'b0);
    rdy = 1'b0;
    check("t2_frame2_data", 32'(bus.o_data), 32'hFAC688);
    check("t2_frame2_valid", 32'(bus.o_valid), 32'd1);
    check("t2_ready_back", 32'(bus.o_ready), 32'd1);
    step(1'b0, '0, 1'b0);
    rdy = 1'b1;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    check("t2_frames", 32'(hs), 32'd2);

    // 3: partial frame closed by flush, then a clean frame
    step(1'b1, 3'd5, 1'b0);
    step(1'b1, 3'd6, 1'b0);
    step(1'b1, 3'd7, 1'b0);
    step(1'b0, '0, 1'b1);
    check("t3_valid", 32'(bus.o_valid), 32'd1);
    check("t3_data", 32'(bus.o_data), 32'hBB8000);
    check("t3_partial", 32'(bus.o_partial), 32'd1);
    foreach (w1[i]) step(1'b1, w1[i], 1'b0);
    step(1'b0, '0, 1'b0);
    check("t3_clean_data", last_data, 32'h29CBBF);
    check("t3_clean_partial", 32'(last_part), 32'd0);

    // 4: flush on empty is ignored; flush with a single word
    hs = 0;
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    check("t4_empty_flush", 32'(hs), 32'd0);
    step(1'b1, 3'd3, 1'b1);
    check("t4_data", 32'(bus.o_data), 32'h600000);
    check("t4_partial", 32'(bus.o_partial), 32'd1);
    step(1'b0, '0, 1'b0);

    // 5: reset mid-frame discards earlier words
    hs = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 3'd5, 1'b0);
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
    foreach (w1[i]) step(1'b1, w1[i], 1'b0);
    step(1'b0, '0, 1'b0);
    check("t5_frames", 32'(hs), 32'd1);
    check("t5_data", last_data, 32'h29CBBF);

    // 6: sustained streaming
    hs = 0; hs_t.delete(); rdy_drop = 1'b0;
    for (int i = 0; i < 24; i++) step(1'b1, 3'(i % 8), 1'b0);
    step(1'b0, '0, 1'b0);
    check("t6_frames", 32'(hs), 32'd3);
    if (hs_t.size() == 3) begin
      check("t6_gap1", 32'(hs_t[1] - hs_t[0]), 32'd8);
      check("t6_gap2", 32'(hs_t[2] - hs_t[1]), 32'd8);
    end
    check("t6_ready_held", 32'(rdy_drop), 32'd0);
    check("t6_data", last_data, 32'h053977);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_tree_in_packer.md
Name: adder_tree_in_packer

Overview:
- Upstream feeder for the CSA adder tree (adder_tree_csa_8_in and its siblings).
- Collects a serial stream of I_DATA_W-bit samples, using a valid/ready handshake, into frames of I_DATA_N words.
- Presents each frame as the packed vector [0:I_DATA_N-1][I_DATA_W-1:0] that the tree consumes.
- Double-buffered (fill buffer plus output register), with flush-and-zero-pad for partial frames.

Parameters:
- I_DATA_W, 3, width of one sample; equals the tree's I_DATA_W.
- I_DATA_N, 8, words per frame; equals the tree's I_DATA_N; legal values are 2 or more.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- i_data  input  I_DATA_W  upstream sample.
- i_valid  input  1  upstream sample valid.
- o_ready  output  1  packer can accept a sample this cycle.
- i_flush  input  1  close the current partial frame; unfilled slots are zero-padded.
- o_data  output  [0:I_DATA_N-1][I_DATA_W-1:0]  frame to the tree; slot 0 holds the first-received sample.
- o_valid  output  1  o_data holds an unconsumed frame.
- i_ready  input  1  downstream takes the frame when o_valid && i_ready.
- o_partial  output  1  the current o_data frame was closed by flush; qualified by o_valid.

Behaviour:
- Reset (rst=1 at an edge):
  - o_valid=0, o_partial=0, o_data=0.
  - Fill buffer cleared to 0; wr_idx=0; state=FILL.
  - o_ready=0 while rst is high; it is 1 in the first cycle after reset.
  - Reset mid-frame discards every partial or held frame. No o_valid results from pre-reset data.
- Definitions:
  - accept = i_valid && o_ready.
  - slot_free = !o_valid || i_ready (output register empty or draining this cycle).
- o_ready = (state==FILL) && !rst. It is combinational from state only and never depends on i_ready.
- State FILL:
  - On accept, i_data is written to slot wr_idx and wr_idx increments.
  - A frame completes when one of these holds:
    - accept with wr_idx==I_DATA_N-1; or
    - i_flush with (wr_idx>0 or accept).
  - A flush that coincides with accept includes that word first.
  - On frame complete with slot_free:
    - o_data <= completed frame (including this cycle's word), o_valid<=1.
    - o_partial <= (frame closed by flush with fewer than I_DATA_N words).
    - Fill buffer cleared to 0, wr_idx<=0, stay in FILL.
  - On frame complete with !slot_free: go to FULL with the frame held in the fill buffer.
  - i_flush with wr_idx==0 and no accept is ignored.
- State FULL:
  - o_ready=0 and i_flush is ignored.
  - When slot_free, transfer the fill buffer to o_data with o_valid=1, clear the buffer, set wr_idx=0, and go to FILL.
- Output register:
  - If downstream consumes with no new frame arriving, o_valid<=0; o_data and o_partial hold their last value.
  - While o_valid && !i_ready, o_data and o_partial are stable.
- Latency: last word accepted at edge t gives o_valid=1 after edge t, provided slot_free.
- Throughput: 1 sample/cycle sustained if downstream accepts at least once per I_DATA_N cycles.
- Full flush frame (exactly I_DATA_N words) has o_partial=0.
- No arithmetic is performed; samples pass bit-exact. Zero padding is all-zero words.

Test Plan (I_DATA_W=3, I_DATA_N=8; o_data written MSB-first, slot 0 at the top bits):
1. Reset, then i_ready=1 and 8 back-to-back words 1,2,3,4,5,6,7,7 -> o_valid high for exactly 1 cycle, on the cycle after the 8th accept; o_data=24'h29CBBF; o_partial=0; o_ready stays 1 throughout.
2. i_ready=0, 16 back-to-back words -> frame 1 held stable in o_data; o_ready drops after the 16th accept (state FULL). Raise i_ready for 1 cycle -> frame 2 appears on o_data the next cycle and o_ready returns to 1.
3. Words 5,6,7 then i_flush -> next cycle o_valid=1, o_data=24'hBB8000, o_partial=1. Following 8 words form a clean frame with o_partial=0.
4. i_flush with empty buffer -> o_valid stays 0. i_flush together with a single word 3 -> o_data=24'h600000, o_partial=1.
5. Four words accepted, then rst for 1 cycle, then 8 words 1..7,7 -> only one o_valid pulse, o_data=24'h29CBBF (pre-reset words absent).
6. 24 continuous words with i_ready=1 -> three o_valid pulses spaced 8 cycles apart; o_ready never deasserts.
